serial_word_receiver: RTL and testbench

- Serial-to-parallel receiver; the receiving end of the serial stream a shift register produces on its left or right serial output.
- Collects framed serial bits, optionally checks an even-parity bit, and presents the assembled word on a registered valid/ready parallel output.
- Sits after a shift-register transmitter, or any bit-serial source, at the boundary to word-wide logic.

---
 rtl/serial_word_receiver_pkg.sv | 14 +
 rtl/serial_word_receiver_word_holding_reg.sv | 81 ++++++++
 rtl/serial_word_receiver.sv | 138 +++++++++++++
 tb/tb_serial_word_receiver.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_word_receiver_pkg.sv
// Shared definitions for the serial word receiver.
//   rx_state_e      : frame assembly state (idle / shifting bits in)
//   ORDER_*         : values of msb_first selecting bit placement order
package serial_word_receiver_pkg;

    typedef enum logic {
        StIdle  = 1'b0,
        StShift = 1'b1
    } rx_state_e;

    localparam logic ORDER_LSB_FIRST = 1'b0;
    localparam logic ORDER_MSB_FIRST = 1'b1;

endpackage

// File: rtl/serial_word_receiver_word_holding_reg.sv
// Output holding register for the serial word receiver.
// Holds the last delivered word with a valid/ready handshake and flags words
// that arrive while the register is still occupied.
//   clk, rst          : clock, synchronous active-low reset
//   word_valid        : a completed word is offered this cycle
//   word_data         : completed data bits
//   word_perr         : parity mismatch of the completed word
//   dout_ready        : consumer accepts p_dout when dout_valid=1
//   clr_err           : clears the sticky overrun flag
//   p_dout            : held word, stable while dout_valid=1
//   dout_valid        : p_dout holds an unconsumed word
//   parity_err        : parity mismatch for the word in p_dout
//   overrun           : sticky, a completed word was dropped
module word_holding_reg #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned PARITY_EN = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             word_valid,
    input  logic [WIDTH-1:0] word_data,
    input  logic             word_perr,
    input  logic             dout_ready,
    input  logic             clr_err,
    output logic [WIDTH-1:0] p_dout,
    output logic             dout_valid,
    output logic             parity_err,
    output logic             overrun
);

    logic [WIDTH-1:0] dout_q, dout_d;
    logic             valid_q, valid_d;
    logic             perr_q, perr_d;
    logic             ovr_q, ovr_d;
    logic             reg_free;

    // A word being consumed on this edge frees the slot for a same-edge load.
    assign reg_free = !valid_q || dout_ready;

    always_comb begin
        dout_d  = dout_q;
        valid_d = valid_q;
        perr_d  = perr_q;
        ovr_d   = ovr_q;

        if (word_valid && reg_free) begin
            dout_d  = word_data;
            valid_d = 1'b1;
            perr_d  = (PARITY_EN != 0) ? word_perr : 1'b0;
        end else if (dout_ready) begin
            valid_d = 1'b0;
        end

        // Set has priority over clear on the same edge.
        if (word_valid && !reg_free) begin
            ovr_d = 1'b1;
        end else if (clr_err) begin
            ovr_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            dout_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            dout_q  <= dout_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign p_dout     = dout_q;
    assign dout_valid = valid_q;
    assign parity_err = perr_q;
    assign overrun    = ovr_q;

endmodule

// File: rtl/serial_word_receiver.sv
// Serial-to-parallel receiver.
// Assembles framed serial bits (optionally followed by an even-parity bit)
// into a WIDTH-bit word and presents it on a registered valid/ready output.
//   clk, rst          : clock, synchronous active-low reset
//   s_din, s_en       : serial bit and its sample strobe
//   s_start           : sampled bit is the first bit of a frame
//   msb_first         : 0 = first bit to p_dout[0], 1 = first bit to p_dout[WIDTH-1]
//   clr_err           : clears sticky overrun and frame_err
//   p_dout/dout_valid : received word and its valid, accepted with dout_ready
//   parity_err        : parity mismatch for the word in p_dout
//   overrun           : sticky, completed word dropped (holding register full)
//   frame_err         : sticky, frame aborted by a new s_start
module serial_word_receiver
    import serial_word_receiver_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned PARITY_EN = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_din,
    input  logic             s_en,
    input  logic             s_start,
    input  logic             msb_first,
    input  logic             clr_err,
    output logic [WIDTH-1:0] p_dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             parity_err,
    output logic             overrun,
    output logic             frame_err
);

    localparam int unsigned FLEN = WIDTH + PARITY_EN;
    localparam int unsigned CW   = $clog2(WIDTH + 2);

    localparam logic [CW-1:0] CNT_LAST  = CW'(FLEN - 1);
    localparam logic [CW-1:0] CNT_WIDTH = CW'(WIDTH);

    rx_state_e        state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             order_q, order_d;
    logic             ferr_q, ferr_d;

    logic             ferr_set;
    logic             word_valid;
    logic [WIDTH-1:0] word_data;
    logic             word_perr;
    logic [WIDTH-1:0] start_word;
    logic [WIDTH-1:0] shifted;

    // First bit of a frame into an empty register, placed per requested order.
    assign start_word = (msb_first == ORDER_MSB_FIRST) ?
                        {{(WIDTH-1){1'b0}}, s_din} : {s_din, {(WIDTH-1){1'b0}}};

    assign shifted = (order_q == ORDER_MSB_FIRST) ?
                     {shreg_q[WIDTH-2:0], s_din} : {s_din, shreg_q[WIDTH-1:1]};

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        cnt_d      = cnt_q;
        order_d    = order_q;
        ferr_set   = 1'b0;
        word_valid = 1'b0;
        word_data  = shreg_q;
        word_perr  = 1'b0;

        if (s_en) begin
            if (s_start) begin
                // Restart wins over completion, even on what would be bit FLEN.
                ferr_set = (state_q == StShift);
                state_d  = StShift;
                shreg_d  = start_word;
                cnt_d    = CW'(1);
                order_d  = msb_first;
            end else if (state_q == StShift) begin
                // Parity bit (count already at WIDTH) never enters the data register.
                if (cnt_q < CNT_WIDTH) begin
                    shreg_d = shifted;
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d    = StIdle;
                    cnt_d      = '0;
                    word_valid = 1'b1;
                    word_data  = shreg_d;
                    word_perr  = (PARITY_EN != 0) ? (^{shreg_q, s_din}) : 1'b0;
                end
            end
        end

        if (ferr_set) begin
            ferr_d = 1'b1;
        end else if (clr_err) begin
            ferr_d = 1'b0;
        end else begin
            ferr_d = ferr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
            shreg_q <= '0;
            cnt_q   <= '0;
            order_q <= ORDER_LSB_FIRST;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            order_q <= order_d;
            ferr_q  <= ferr_d;
        end
    end

    assign frame_err = ferr_q;

    word_holding_reg #(
        .WIDTH     (WIDTH),
        .PARITY_EN (PARITY_EN)
    ) u_hold (
        .clk        (clk),
        .rst        (rst),
        .word_valid (word_valid),
        .word_data  (word_data),
        .word_perr  (word_perr),
        .dout_ready (dout_ready),
        .clr_err    (clr_err),
        .p_dout     (p_dout),
        .dout_valid (dout_valid),
        .parity_err (parity_err),
        .overrun    (overrun)
    );

endmodule

// File: tb/tb_serial_word_receiver.sv
// Bench for serial_word_receiver: one instance without parity (index 0) and
// one with even parity (index 1) share the same serial stimulus. A frame-level
// model predicts every output each cycle; directed checks pin known words.
module tb_serial_word_receiver;

    localparam int W = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic s_din = 1'b0;
    logic s_en = 1'b0;
    logic s_start = 1'b0;
    logic msb_first = 1'b0;
    logic clr_err = 1'b0;
    logic dout_ready = 1'b0;

    logic [W-1:0] pd [2];
    logic         dv [2];
    logic         pe [2];
    logic         ov [2];
    logic         fe [2];

    int n_cmp = 0;
    int n_fail = 0;
    bit started = 1'b0;

    always #5 clk = ~clk;

    serial_word_receiver #(.WIDTH(W), .PARITY_EN(0)) dut0 (
        .clk        (clk),
        .rst        (rst),
        .s_din      (s_din),
        .s_en       (s_en),
        .s_start    (s_start),
        .msb_first  (msb_first),
        .clr_err    (clr_err),
        .p_dout     (pd[0]),
        .dout_valid (dv[0]),
        .dout_ready (dout_ready),
        .parity_err (pe[0]),
        .overrun    (ov[0]),
        .frame_err  (fe[0])
    );

    serial_word_receiver #(.WIDTH(W), .PARITY_EN(1)) dut1 (
        .clk        (clk),
        .rst        (rst),
        .s_din      (s_din),
        .s_en       (s_en),
        .s_start    (s_start),
        .msb_first  (msb_first),
        .clr_err    (clr_err),
        .p_dout     (pd[1]),
        .dout_valid (dv[1]),
        .dout_ready (dout_ready),
        .parity_err (pe[1]),
        .overrun    (ov[1]),
        .frame_err  (fe[1])
    );

    // ---------------- frame-level model ----------------
    bit           m_in    [2];
    int           m_cnt   [2];
    bit           m_bits  [2][8];
    bit           m_ord   [2];
    logic [W-1:0] m_dout  [2];
    bit           m_valid [2];
    bit           m_perr  [2];
    bit           m_ovr   [2];
    bit           m_ferr  [2];

    task automatic model_step(input int i);
        int           flen;
        bit           load;
        bit           fset;
        bit           free;
        bit           par;
        logic [W-1:0] word;
        flen = W + i;
        load = 1'b0;
        fset = 1'b0;
        par  = 1'b0;
        word = '0;
        if (!rst) begin
            m_in[i] = 0; m_cnt[i] = 0; m_dout[i] = '0; m_valid[i] = 0;
            m_perr[i] = 0; m_ovr[i] = 0; m_ferr[i] = 0;
            return;
        end
        if (s_en) begin
            if (s_start) begin
                fset = m_in[i];
                m_in[i] = 1;
                m_ord[i] = msb_first;
                m_bits[i][0] = s_din;
                m_cnt[i] = 1;
            end else if (m_in[i]) begin
                m_bits[i][m_cnt[i]] = s_din;
                m_cnt[i]++;
                if (m_cnt[i] == flen) begin
                    m_in[i] = 0;
                    load = 1;
                end
            end
        end
        if (load) begin
            for (int k = 0; k < W; k++) begin
                if (m_ord[i]) word[W-1-k] = m_bits[i][k];
                else          word[k]     = m_bits[i][k];
            end
            if (i == 1) begin
                par = m_bits[i][W];
                for (int k = 0; k < W; k++) par ^= m_bits[i][k];
            end
        end
        free = !m_valid[i] || dout_ready;
        if (load && free) begin
            m_dout[i] = word; m_valid[i] = 1; m_perr[i] = par;
        end else if (dout_ready) begin
            m_valid[i] = 0;
        end
        if (load && !free) m_ovr[i] = 1;
        else if (clr_err)  m_ovr[i] = 0;
        if (fset)          m_ferr[i] = 1;
        else if (clr_err)  m_ferr[i] = 0;
    endtask

    always @(posedge clk) begin
        model_step(0);
        model_step(1);
        started = 1'b1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (started) begin
            for (int i = 0; i < 2; i++) begin
                check($sformatf("model p_dout[%0d]", i), 32'(pd[i]), 32'(m_dout[i]));
                check($sformatf("model dout_valid[%0d]", i), 32'(dv[i]), 32'(m_valid[i]));
                check($sformatf("model parity_err[%0d]", i), 32'(pe[i]), 32'(m_perr[i]));
                check($sformatf("model overrun[%0d]", i), 32'(ov[i]), 32'(m_ovr[i]));
                check($sformatf("model frame_err[%0d]", i), 32'(fe[i]), 32'(m_ferr[i]));
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input bit b, input bit st);
        s_en = 1'b1; s_din = b; s_start = st;
        tick();
        s_en = 1'b0; s_start = 1'b0; s_din = 1'b0;
    endtask

    task automatic gap(input int n);
        repeat (n) tick();
    endtask

    initial begin
        // Reset
        rst = 1'b0;
        gap(2);
        check("reset p_dout", 32'(pd[0]), 32'h0);
        check("reset dout_valid", 32'(dv[0]), 32'h0);
        check("reset flags", 32'({ov[0], fe[0], pe[0], ov[1], fe[1], pe[1]}), 32'h0);
        rst = 1'b1;

        // LSB-first 1,1,0,1 -> 4'hB, consumed next edge
        dout_ready = 1'b1;
        msb_first  = 1'b0;
        send(1, 1); send(1, 0); send(0, 0); send(1, 0);
        check("lsb word", 32'(pd[0]), 32'hB);
        check("lsb valid", 32'(dv[0]), 32'h1);
        tick();
        check("lsb consumed", 32'(dv[0]), 32'h0);
        check("lsb held after consume", 32'(pd[0]), 32'hB);

        // MSB-first with gaps; bit before s_start ignored
        msb_first = 1'b1;
        send(1, 0);
        check("idle bit ignored", 32'(dv[0]), 32'h0);
        send(1, 1); gap(2);
        send(0, 0); gap(2);
        send(1, 0); gap(2);
        send(1, 0);
        check("msb word", 32'(pd[0]), 32'hB);
        check("msb valid", 32'(dv[0]), 32'h1);
        tick();

        // Overrun with consumer stalled
        dout_ready = 1'b0;
        msb_first  = 1'b0;
        send(1, 1); send(1, 0); send(0, 0); send(1, 0);
        send(1, 1); send(0, 0); send(1, 0); send(0, 0);
        check("overrun set", 32'(ov[0]), 32'h1);
        check("overrun word kept", 32'(pd[0]), 32'hB);
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        check("overrun cleared", 32'(ov[0]), 32'h0);
        dout_ready = 1'b1;
        tick();

        // Frame abort after 2 bits, then 0,1,1,0 -> 4'h6
        send(1, 1); send(0, 0);
        send(0, 1); send(1, 0); send(1, 0); send(0, 0);
        check("abort frame_err", 32'(fe[0]), 32'h1);
        check("abort word", 32'(pd[0]), 32'h6);
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        check("frame_err cleared", 32'(fe[0]), 32'h0);

        // s_start on bit FLEN restarts; set beats clr_err on the same edge
        send(1, 1); send(0, 0); send(1, 0);
        clr_err = 1'b1; send(1, 1); clr_err = 1'b0;
        check("restart set wins", 32'(fe[0]), 32'h1);
        check("restart no word", 32'(dv[0]), 32'h0);
        send(0, 0); send(0, 0); send(1, 0);
        check("restart word", 32'(pd[0]), 32'h9);
        clr_err = 1'b1; tick(); clr_err = 1'b0;

        // Parity instance: good then bad parity
        send(1, 1); send(1, 0); send(0, 0); send(1, 0); send(1, 0);
        check("parity ok word", 32'(pd[1]), 32'hB);
        check("parity ok", 32'(pe[1]), 32'h0);
        send(1, 1); send(1, 0); send(0, 0); send(1, 0); send(0, 0);
        check("parity bad word", 32'(pd[1]), 32'hB);
        check("parity bad", 32'(pe[1]), 32'h1);

        // Reset mid-frame discards it without frame_err
        send(1, 1); send(0, 0);
        rst = 1'b0; tick(); rst = 1'b1;
        check("midreset valid", 32'(dv[1]), 32'h0);
        check("midreset frame_err", 32'(fe[1]), 32'h0);
        send(1, 0); send(1, 0); send(1, 0);
        check("midreset tail ignored", 32'(dv[1]), 32'h0);
        send(0, 1); send(1, 0); send(1, 0); send(0, 0); send(0, 0);
        check("post reset word", 32'(pd[1]), 32'h6);
        check("post reset no frame_err", 32'(fe[1]), 32'h0);
        check("post reset parity", 32'(pe[1]), 32'h0);

        gap(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
